// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file with pending scoreboard.
// Imported by the storage top and the scoreboard tracker.
package regfile_scoreboard_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int ZERO_REG_ADDR = 0;

  function automatic int portLsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_track.sv
// Pending-producer scoreboard: one bit per register, set on issue,
// cleared by load writeback; also derives issue_ready and rd_busy.
module regfile_sb_track
  import regfile_scoreboard_pkg::*;
#(
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     issue_ready,
  output logic [DEPTH-1:0]         pending
);

  logic [DEPTH-1:0] pendingNext;
  logic             issueAccept;
  logic             zeroIssue;
  logic             wr1Resolves;

  assign zeroIssue = (ZERO_REG != 0) &&
                     (issue_addr == ADDR_W'(ZERO_REG_ADDR));

  assign wr1Resolves = wr1_en && (wr1_addr == issue_addr);
  assign issue_ready = ~pending[issue_addr] | wr1Resolves;
  assign issueAccept = issue_en & issue_ready & ~zeroIssue;

  // Set after clear so a new producer replaces a resolving one.
  always_comb begin
    pendingNext = pending;
    if (wr1_en)
      pendingNext[wr1_addr] = 1'b0;
    if (issueAccept)
      pendingNext[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= pendingNext;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gBusy
    logic [ADDR_W-1:0] addr;
    logic              fwd;
    assign addr = rd_addr[portLsb(k, ADDR_W) +: ADDR_W];
    assign fwd  = (BYPASS != 0) && wr1_en && (wr1_addr == addr);
    assign rd_busy[k] = pending[addr] & ~fwd;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file: NUM_RD combinational reads, ALU and load
// write ports, optional bypass and zero register, pending scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic [DEPTH-1:0]         pending
);

  logic [DATA_W-1:0] regs [DEPTH];

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_REG_ADDR));
  endfunction

  // wr1 is applied last so it wins an address collision with wr0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (wr0_en && !isZero(wr0_addr))
        regs[wr0_addr] <= wr0_data;
      if (wr1_en && !isZero(wr1_addr))
        regs[wr1_addr] <= wr1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    assign addr = rd_addr[portLsb(k, ADDR_W) +: ADDR_W];
    always_comb begin
      val = regs[addr];
      if (BYPASS != 0) begin
        if (wr1_en && wr1_addr == addr)
          val = wr1_data;
        else if (wr0_en && wr0_addr == addr)
          val = wr0_data;
      end
      if (isZero(addr))
        val = '0;
    end
    assign rd_data[portLsb(k, DATA_W) +: DATA_W] = val;
  end

  regfile_sb_track #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) uTrack (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_busy    (rd_busy),
    .issue_ready(issue_ready),
    .pending    (pending)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, reset corner case and
// random traffic against a register/pending model (bypass on and off).
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rd_addr;
  logic        wr0_en, wr1_en, issue_en;
  logic [3:0]  wr0_addr, wr1_addr, issue_addr;
  logic [15:0] wr0_data, wr1_data;
  logic [31:0] rd_data, rdDataNb;
  logic [1:0]  rd_busy, rdBusyNb;
  logic        issue_ready, issueReadyNb;
  logic [15:0] pending, pendingNb;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] mRegs [16];
  logic        mPend [16];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .pending(pending)
  );

  regfile_scoreboard #(.BYPASS(0)) dutNb (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rdDataNb), .rd_busy(rdBusyNb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .issue_ready(issueReadyNb), .pending(pendingNb)
  );

  typedef struct {
    logic        w0e; logic [3:0] w0a; logic [15:0] w0d;
    logic        w1e; logic [3:0] w1a; logic [15:0] w1d;
    logic        ie;  logic [3:0] ia;
    logic [3:0]  r0;  logic [3:0] r1;
    logic [15:0] e0;  logic [15:0] e1; logic [15:0] eNb0;
    logic [1:0]  eBusy; logic eReady; logic [15:0] ePend;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp)
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    else
      nPass++;
  endtask

  task automatic mdlClear();
    for (int i = 0; i < 16; i++) begin
      mRegs[i] = 16'h0;
      mPend[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] expRd(input logic [3:0] a,
                                        input bit byp);
    if (a == 4'd0) return 16'h0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input logic [3:0] a, input bit byp);
    return mPend[a] && !(byp && wr1_en && wr1_addr == a);
  endfunction

  function automatic logic expReady();
    return !mPend[issue_addr] || (wr1_en && wr1_addr == issue_addr);
  endfunction

  function automatic logic [15:0] expPendVec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mPend[i];
    return v;
  endfunction

  task automatic mdlStep();
    logic ok;
    ok = expReady();
    if (reset) begin
      mdlClear();
    end else begin
      if (wr0_en && wr0_addr != 4'd0) mRegs[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 4'd0) mRegs[wr1_addr] = wr1_data;
      if (wr1_en) mPend[wr1_addr] = 1'b0;
      if (issue_en && ok && issue_addr != 4'd0) mPend[issue_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 16'h0;
    wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 16'h0;
    issue_en = 1'b0; issue_addr = 4'd0;
  endtask

  // Inputs are set by the caller just after a rising edge.
  task automatic modelCycle(input string tag);
    logic [3:0] a0, a1;
    if (reset) mdlClear();
    #1;
    a0 = rd_addr[3:0];
    a1 = rd_addr[7:4];
    chk({tag, " rd0"}, rd_data[15:0], expRd(a0, 1));
    chk({tag, " rd1"}, rd_data[31:16], expRd(a1, 1));
    chk({tag, " busy"}, rd_busy, {expBusy(a1, 1), expBusy(a0, 1)});
    chk({tag, " ready"}, issue_ready, expReady());
    chk({tag, " nb rd0"}, rdDataNb[15:0], expRd(a0, 0));
    chk({tag, " nb rd1"}, rdDataNb[31:16], expRd(a1, 0));
    chk({tag, " nb busy"}, rdBusyNb, {expBusy(a1, 0), expBusy(a0, 0)});
    mdlStep();
    @(posedge clk);
    #1;
    chk({tag, " pend"}, pending, expPendVec());
    chk({tag, " nb pend"}, pendingNb, expPendVec());
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0,
                4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 16'h0000, 2'b00, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0,
                4'd3, 4'd5, 16'hBEEF, 16'h0000, 16'hBEEF, 2'b00, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, 4'd0,
                4'd5, 4'd3, 16'h2222, 16'hBEEF, 16'h0000, 2'b00, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0,
                4'd0, 4'd5, 16'h0000, 16'h2222, 16'h0000, 2'b00, 1'b1, 16'h0000};
    tbl[4]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7,
                4'd0, 4'd5, 16'h0000, 16'h2222, 16'h0000, 2'b00, 1'b1, 16'h0080};
    tbl[5]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7,
                4'd7, 4'd3, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 1'b0, 16'h0080};
    tbl[6]  = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd7,
                4'd7, 4'd7, 16'h00AA, 16'h00AA, 16'h0000, 2'b00, 1'b1, 16'h0000};
    tbl[7]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0,
                4'd7, 4'd5, 16'h00AA, 16'h2222, 16'h00AA, 2'b00, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9,
                4'd9, 4'd9, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0200};
    tbl[9]  = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h1234, 1'b1, 4'd9,
                4'd9, 4'd0, 16'h1234, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0200};
    tbl[10] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd9,
                4'd9, 4'd7, 16'h1234, 16'h00AA, 16'h1234, 2'b01, 1'b0, 16'h0200};
    tbl[11] = '{1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0,
                4'd0, 4'd9, 16'h0000, 16'h1234, 16'h0000, 2'b10, 1'b1, 16'h0200};
    tbl[12] = '{1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h5555, 1'b0, 4'd0,
                4'd9, 4'd9, 16'h5555, 16'h5555, 16'h1234, 2'b00, 1'b1, 16'h0000};

    reset = 1'b1;
    rd_addr = 8'h00;
    idle();
    mdlClear();
    #1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(a)};
      issue_addr = 4'(a);
      #1;
      chk($sformatf("reset rd r%0d", a), rd_data, 32'h0);
      chk($sformatf("reset busy r%0d", a), rd_busy, 2'b00);
      chk($sformatf("reset ready r%0d", a), issue_ready, 1'b1);
    end
    chk("reset pend", pending, 16'h0);
    issue_addr = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      wr0_en = tbl[i].w0e; wr0_addr = tbl[i].w0a; wr0_data = tbl[i].w0d;
      wr1_en = tbl[i].w1e; wr1_addr = tbl[i].w1a; wr1_data = tbl[i].w1d;
      issue_en = tbl[i].ie; issue_addr = tbl[i].ia;
      rd_addr = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("vec%0d rd0", i), rd_data[15:0], tbl[i].e0);
      chk($sformatf("vec%0d rd1", i), rd_data[31:16], tbl[i].e1);
      chk($sformatf("vec%0d nb rd0", i), rdDataNb[15:0], tbl[i].eNb0);
      chk($sformatf("vec%0d busy", i), rd_busy, tbl[i].eBusy);
      chk($sformatf("vec%0d ready", i), issue_ready, tbl[i].eReady);
      mdlStep();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pend", i), pending, tbl[i].ePend);
    end

    // Reset lands between an issue and its writeback.
    idle();
    issue_en = 1'b1; issue_addr = 4'd2;
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 16'h7777;
    rd_addr = {4'd5, 4'd2};
    modelCycle("pre-reset");
    chk("pre-reset pend2", pending[2], 1'b1);
    idle();
    wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 16'h9999;
    #1;
    wr0_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset pend", pending, 16'h0);
    chk("midreset r2", rd_data[15:0], 16'h0);
    chk("midreset r5", rd_data[31:16], 16'h0);
    wr0_en = 1'b1;
    mdlClear();
    @(posedge clk);
    #3;
    wr0_en = 1'b0;
    reset = 1'b0;
    rd_addr = {4'd4, 4'd2};
    #1;
    chk("postreset r4", rd_data[31:16], 16'h0);
    chk("postreset busy", rd_busy, 2'b00);
    @(posedge clk);
    #1;
    idle();
    wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 16'h0042;
    rd_addr = {4'd2, 4'd2};
    modelCycle("plain wr1");
    idle();
    #1;
    chk("plain wr1 r2", rd_data[15:0], 16'h0042);
    chk("plain wr1 pend", pending, 16'h0);

    for (int c = 0; c < 400; c++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      rd_addr = 8'($urandom);
      issue_addr = 4'($urandom_range(0, 7));
      if (!reset) begin
        wr0_en = ($urandom_range(0, 2) == 0);
        wr0_addr = 4'($urandom_range(0, 7));
        wr0_data = 16'($urandom);
        wr1_en = ($urandom_range(0, 2) == 0);
        wr1_addr = 4'($urandom_range(0, 7));
        wr1_data = 16'($urandom);
        issue_en = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 1) == 0)
          rd_addr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      end
      modelCycle($sformatf("rnd%0d", c));
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
